// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, S-box lookup and shared types
package aes_pkg;

  localparam int NUM_ROUNDS_128 = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

  // Entry 0 is unused; round r of the schedule uses RCON[r].
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational AES-128 key-expansion round
module aes_key_step
  import aes_pkg::*;
(
  input  block_t      prev,
  input  logic [7:0]  rcon,
  output block_t      next
);

  word_t w0, w1, w2, w3;
  word_t rot, t;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev;

  // RotWord: top byte moves to the bottom.
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion into a registered round-key bank
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128
)
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          key_valid_i,
  output logic                          key_ready_o,
  input  logic [127:0]                  key_i,
  output logic                          busy_o,
  output logic                          keys_valid_o,
  output logic [(NUM_ROUNDS+1)*128-1:0] round_keys_o
);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("aes_key_schedule supports only NUM_ROUNDS = 10");
  end

  ks_state_t  state_q, state_d;
  logic [3:0] cnt;
  logic [3:0] cnt_prev;
  logic       keys_valid_q;
  block_t     bank [NUM_ROUNDS+1];
  block_t     step_key;
  logic       accept;
  logic       last_step;

  assign key_ready_o  = (state_q != ST_EXPAND);
  assign busy_o       = (state_q == ST_EXPAND);
  assign keys_valid_o = keys_valid_q;
  assign accept       = key_valid_i & key_ready_o;
  assign last_step    = (cnt == 4'(NUM_ROUNDS));
  assign cnt_prev     = cnt - 4'd1;

  // Single step unit, time-multiplexed over the rounds by cnt.
  aes_key_step u_step (
    .prev (bank[cnt_prev]),
    .rcon (RCON[cnt]),
    .next (step_key)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (key_valid_i) state_d = ST_EXPAND;
      ST_EXPAND:        if (last_step)   state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt          <= 4'd0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) bank[i] <= '0;
    end else if (state_q == ST_EXPAND) begin
      bank[cnt] <= step_key;
      if (last_step) begin
        keys_valid_q <= 1'b1;
        cnt          <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else if (accept) begin
      bank[0]      <= key_i;
      cnt          <= 4'd1;
      keys_valid_q <= 1'b0;
    end
  end

  for (genvar r = 0; r <= NUM_ROUNDS; r++) begin : g_out
    assign round_keys_o[r*128 +: 128] = bank[r];
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - randomized self-checking bench against a FIPS-197 key-expansion model
module tb_aes_key_schedule;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          key_valid_i = 1'b0;
  logic          key_ready_o;
  logic [127:0]  key_i = '0;
  logic          busy_o;
  logic          keys_valid_o;
  logic [1407:0] round_keys_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]   sb [256];
  logic [127:0] mdl [11];

  aes_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .keys_valid_o (keys_valid_o),
    .round_keys_o (round_keys_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over the 44-word schedule.
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_bank(input string tag, input logic [127:0] k);
    model(k);
    for (int r = 0; r < 11; r++)
      chk($sformatf("%s_rk%0d", tag, r), round_keys_o[r*128 +: 128], mdl[r]);
  endtask

  // Counts busy cycles from the current negedge until keys_valid_o rises.
  task automatic wait_done(output int n);
    n = 0;
    while (!keys_valid_o && n < 30) begin
      if (busy_o) n++;
      @(negedge clk_i);
    end
  endtask

  // Offers a key at a negedge; returns at the first negedge with keys_valid_o high.
  task automatic run_key(input string tag, input logic [127:0] k);
    int n;
    key_valid_i = 1'b1;
    key_i       = k;
    @(posedge clk_i);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    chk({tag, "_valid_drop"}, 128'(keys_valid_o), 128'd0);
    chk({tag, "_ready_low"},  128'(key_ready_o),  128'd0);
    wait_done(n);
    chk({tag, "_busy_cycles"}, 128'(n), 128'd10);
    check_bank(tag, k);
  endtask

  logic [127:0] ka, kb;
  logic [127:0] rk_keys [6];
  int           n;

  initial begin
    build_sbox();

    repeat (3) @(negedge clk_i);
    chk("rst_ready", 128'(key_ready_o),  128'd1);
    chk("rst_busy",  128'(busy_o),       128'd0);
    chk("rst_valid", 128'(keys_valid_o), 128'd0);
    for (int r = 0; r < 11; r++) chk($sformatf("rst_rk%0d", r), round_keys_o[r*128 +: 128], 128'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_rk0_const",  round_keys_o[0 +: 128],    128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_rk1_const",  round_keys_o[128 +: 128],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10_const", round_keys_o[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (5) @(negedge clk_i);
    chk("done_hold_valid", 128'(keys_valid_o), 128'd1);
    chk("done_hold_ready", 128'(key_ready_o),  128'd1);
    check_bank("done_hold", 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_key("zero", 128'h0);
    chk("zero_rk1_const",  round_keys_o[128 +: 128],  128'h62636363626363636263636362636363);
    chk("zero_rk10_const", round_keys_o[1280 +: 128], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    key_valid_i = 1'b1;
    key_i       = ka;
    @(posedge clk_i);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    key_valid_i = 1'b1;
    key_i       = kb;
    chk("pulse_ready_low", 128'(key_ready_o), 128'd0);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    wait_done(n);
    chk("pulse_busy_rest", 128'(n), 128'd6);
    check_bank("pulse", ka);

    key_valid_i = 1'b1;
    key_i       = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_i);
    @(negedge clk_i);
    key_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", 128'(key_ready_o),  128'd1);
    chk("arst_busy",  128'(busy_o),       128'd0);
    chk("arst_valid", 128'(keys_valid_o), 128'd0);
    chk("arst_rk0",   round_keys_o[0 +: 128],   128'd0);
    chk("arst_rk3",   round_keys_o[384 +: 128], 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("arst_release_ready", 128'(key_ready_o), 128'd1);
    run_key("post_rst", {$urandom, $urandom, $urandom, $urandom});

    for (int i = 0; i < 6; i++) rk_keys[i] = {$urandom, $urandom, $urandom, $urandom};
    key_valid_i = 1'b1;
    key_i       = rk_keys[0];
    @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b%0d_busy", i),  128'(busy_o),       128'd1);
      chk($sformatf("b2b%0d_valid", i), 128'(keys_valid_o), 128'd0);
      key_i = rk_keys[i+1];
      wait_done(n);
      chk($sformatf("b2b%0d_busy_cycles", i), 128'(n), 128'd10);
      chk($sformatf("b2b%0d_done_ready", i), 128'(key_ready_o), 128'd1);
      check_bank($sformatf("b2b%0d", i), rk_keys[i]);
      @(negedge clk_i);
    end
    key_valid_i = 1'b0;
    wait_done(n);
    chk("b2b_last_busy_cycles", 128'(n), 128'd10);
    check_bank("b2b_last", rk_keys[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion. Generates the 11 round keys that the round-stage cores (CORENUM 0..10) consume on their 128-bit key inputs.
- Accepts one cipher key through a valid/ready handshake and produces one round key per clock into an internal key bank.
- Presents the whole bank, flattened, to the unrolled round pipeline. Sits directly upstream of the round cores' key inputs.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds. Only 10 (AES-128) is supported; elaboration fails on any other value.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- key_valid_i  input  1  cipher key offered.
- key_ready_o  output  1  block can accept a key.
- key_i  input  128  cipher key. FIPS-197 byte 0 at [127:120]; word w0 = [127:96].
- busy_o  output  1  expansion in progress.
- keys_valid_o  output  1  full bank is valid and stable.
- round_keys_o  output  (NUM_ROUNDS+1)*128  round key r at [r*128 +: 128]. r=0 is the cipher key and feeds core 0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, round counter=0, all bank entries=0.
  - keys_valid_o=0, busy_o=0, key_ready_o=1.
- States:
  - IDLE, EXPAND, DONE.
  - key_ready_o = (state!=EXPAND), combinational from state.
  - busy_o = (state==EXPAND).
- Accept: on a clock edge with key_valid_i & key_ready_o (from IDLE or DONE):
  - bank[0] <= key_i, cnt <= 1, keys_valid_o <= 0, state <= EXPAND.
- EXPAND, each edge:
  - bank[cnt] <= step(bank[cnt-1], RCON[cnt]), cnt <= cnt+1.
  - On the edge where cnt==NUM_ROUNDS: write bank[10], keys_valid_o <= 1, state <= DONE, cnt <= 0.
- Latency: accept edge = edge 0. rk1..rk10 are written on edges 1..10. keys_valid_o is high after edge 10, i.e. 10 cycles of busy_o.
- step function (one key-expansion round):
  - t = SubWord(RotWord(w3)) ^ {RCON,24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord moves the top byte to the bottom.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Boundary conditions:
  - key_valid_i during EXPAND: ignored (ready low). The key is not latched and the current expansion is unaffected.
  - New key accepted in DONE: keys_valid_o drops the following cycle. The bank is overwritten progressively, so consumers must not use round_keys_o while keys_valid_o=0.
  - DONE holds indefinitely. The bank stays stable while keys_valid_o=1.
  - key_valid_i held high continuously: re-accepts on the first DONE cycle. The next expansion starts with no idle gap.
  - Reset mid-EXPAND: everything returns to reset values immediately. No partial key is exposed with keys_valid_o=1.
  - cnt is 4 bits and never exceeds NUM_ROUNDS. There is no wrap.
- Bank entries are registers. round_keys_o is driven directly from the bank, with no combinational path from key_i.

Decomposition:
- Package aes_pkg:
  - NUM_ROUNDS_128=10, RCON constant array, sbox lookup function.
  - word_t (32-bit) and block_t (128-bit) typedefs.
  - Also shared by the round cores.
- Sub-module aes_key_step (combinational):
  - Inputs: prev round key, rcon byte. Output: next round key.
  - Contains 4 S-box lookups.
  - Instantiated once and time-multiplexed by the counter.

Test Plan:
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c -> after 10 busy cycles keys_valid_o=1; rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; rk0 equals key.
- All-zero key -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e; all 11 keys match the reference model.
- key_valid_i pulsed with a different key on cycle 4 of EXPAND -> key_ready_o=0, the key is ignored, and the bank equals the first key's expansion.
- In DONE, apply the zero key -> keys_valid_o=0 next cycle, busy_o=1 for 10 cycles, then valid again with the zero-key bank.
- Assert rst_ni low at cycle 6 of EXPAND -> outputs go to reset values asynchronously; after release key_ready_o=1, and a fresh key expands correctly.
- key_valid_i tied high with random keys -> back-to-back expansions, each reaching DONE for exactly one cycle before re-accept; every bank checked against the model.
